// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 pipeline control logic: instruction codes,
// the "no register" id, status codes and the control FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] RNONE    = 4'hF;

    // Status codes
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_HLT    = 3'd2;
    localparam logic [2:0] S_ADR    = 3'd3;
    localparam logic [2:0] S_INS    = 3'd4;

    // Control FSM states
    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fsm_t;

    // True for instructions that write a register from memory in the M stage
    function automatic logic is_mem_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
// One saturating performance counter. Sticks at all-ones instead of wrapping.
// A clear (or reset) wins over a same-cycle increment.
// Ports:
//   clk    in   1      clock
//   reset  in   1      synchronous, active-high
//   inc    in   1      add one this edge (ignored when saturated)
//   clr    in   1      zero the counter this edge
//   cnt    out  CNT_W  current count (registered)
//   sat    out  1      counter is at all-ones
// -----------------------------------------------------------------------------
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign sat = &cnt;

    // Count register: clear has priority, increment stops at all-ones
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + ONE;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline control unit for the 5-stage Y86-64 core. Produces the stall/bubble
// controls for the F/D/E/M/W pipeline registers and the E-stage CC write
// enable, runs a FLUSH/RUN/HALTED state machine and keeps four saturating
// performance counters. Control outputs are combinational because the
// pipeline registers consume them in the same cycle.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   D_icode, d_srcA, d_srcB     decode-stage icode and source registers
//   E_icode, E_dstM, e_Cnd      execute-stage icode, load destination, jXX cond
//   M_icode, m_stat             memory-stage icode and produced status
//   W_stat, W_icode             writeback-stage status and icode
//   clr_cnt                     synchronous clear of the perf counters
//   F_stall..W_stall, cc_en     pipeline register controls / CC enable
//   halted                      core stopped on a non-AOK writeback status
//   cyc_cnt, ret_cnt,
//   lu_cnt, mp_cnt              RUN cycles, retirements, load-use stalls,
//                               mispredicts
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic             clr_cnt,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             cc_en,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    fsm_t state_r;
    fsm_t state_s;

    logic lu_s;
    logic mp_s;
    logic rt_s;
    logic exc_s;
    logic w_bad_s;
    logic run_s;

    logic cyc_sat_s;
    logic ret_sat_s;
    logic lu_sat_s;
    logic mp_sat_s;

    // Hazard terms decoded from the current pipeline register contents
    always_comb begin
        lu_s    = is_mem_load(E_icode) && (E_dstM != RNONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mp_s    = (E_icode == I_JXX) && !e_Cnd;
        rt_s    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        w_bad_s = (W_stat != S_AOK);
        exc_s   = (m_stat != S_AOK) || w_bad_s;
    end

    // Next-state logic: FLUSH lasts one cycle, HALTED is left only via reset
    always_comb begin
        state_s = state_r;
        case (state_r)
            FLUSH:   state_s = RUN;
            RUN:     state_s = w_bad_s ? HALTED : RUN;
            HALTED:  state_s = HALTED;
            default: state_s = FLUSH;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FLUSH;
        end else begin
            state_r <= state_s;
        end
    end

    // Pipeline controls; reset forces the flush pattern regardless of state
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b0;
        cc_en    = 1'b0;
        if (reset) begin
            F_stall = 1'b1;
        end else begin
            case (state_r)
                FLUSH: begin
                    F_stall = 1'b1;
                end
                RUN: begin
                    // lu with rt: holding D already keeps the ret in place,
                    // so D must not also be bubbled
                    F_stall  = lu_s | rt_s;
                    D_stall  = lu_s;
                    D_bubble = mp_s | (rt_s & ~lu_s);
                    E_bubble = mp_s | lu_s;
                    M_bubble = exc_s;
                    W_stall  = w_bad_s;
                    cc_en    = ~exc_s;
                end
                HALTED: begin
                    D_stall  = 1'b1;
                    D_bubble = 1'b0;
                    W_stall  = 1'b1;
                end
                default: begin
                    F_stall = 1'b1;
                end
            endcase
        end
    end

    assign halted = (state_r == HALTED);
    assign run_s  = (state_r == RUN);

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (run_s),
        .clr   (clr_cnt),
        .cnt   (cyc_cnt),
        .sat   (cyc_sat_s)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (run_s && !w_bad_s && (W_icode != I_NOP)),
        .clr   (clr_cnt),
        .cnt   (ret_cnt),
        .sat   (ret_sat_s)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (run_s && lu_s),
        .clr   (clr_cnt),
        .cnt   (lu_cnt),
        .sat   (lu_sat_s)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_mp_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (run_s && mp_s),
        .clr   (clr_cnt),
        .cnt   (mp_cnt),
        .sat   (mp_sat_s)
    );

    // Saturation flags are informational only at this level
    logic unused_sat_s;
    assign unused_sat_s = cyc_sat_s ^ ret_sat_s ^ lu_sat_s ^ mp_sat_s;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl with 4-bit counters so saturation is
// reachable. A behavioural model tracks the control mode and the counters and
// is compared with the DUT on every falling edge; literal checks at chosen
// points pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    import y86_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic         e_Cnd, clr_cnt;
    logic [2:0]   m_stat, W_stat;
    logic         F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, cc_en, halted;
    logic [W-1:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.CNT_W(W)) dut (
        .clk(clk), .reset(reset),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
        .clr_cnt(clr_cnt),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .cc_en(cc_en), .halted(halted),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit           m_flush = 1'b1;   // first cycle after reset still flushing
    bit           m_halt  = 1'b0;
    bit           chk_en  = 1'b0;
    logic [W-1:0] m_cyc = '0, m_ret = '0, m_lu = '0, m_mp = '0;

    function automatic logic [W-1:0] bump(input logic [W-1:0] v);
        return (v == {W{1'b1}}) ? v : v + 4'd1;
    endfunction

    function automatic bit load_use();
        return (E_icode == I_MRMOVQ || E_icode == I_POPQ) && E_dstM != RNONE &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
    endfunction

    function automatic bit mispredict();
        return E_icode == I_JXX && e_Cnd == 1'b0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_flush = 1'b1;
            m_halt  = 1'b0;
            m_cyc = '0; m_ret = '0; m_lu = '0; m_mp = '0;
        end else begin
            if (!m_flush && !m_halt) begin
                m_cyc = bump(m_cyc);
                if (W_stat == S_AOK && W_icode != I_NOP) m_ret = bump(m_ret);
                if (load_use())   m_lu = bump(m_lu);
                if (mispredict()) m_mp = bump(m_mp);
                if (W_stat != S_AOK) m_halt = 1'b1;
            end
            m_flush = 1'b0;
            if (clr_cnt) begin
                m_cyc = '0; m_ret = '0; m_lu = '0; m_mp = '0;
            end
        end
        chk_en = 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [7:0] exp_v, act_v;
        bit lu, mp, rt, exc;
        if (chk_en) begin
            lu  = load_use();
            mp  = mispredict();
            rt  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
            exc = (m_stat != S_AOK) || (W_stat != S_AOK);
            // order: F_stall D_stall D_bubble E_bubble M_bubble W_stall cc_en halted
            if (reset || m_flush)
                exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, m_halt};
            else if (m_halt)
                exp_v = 8'b1101_1101;
            else
                exp_v = {lu | rt, lu, mp | (rt & !lu), mp | lu, exc,
                         W_stat != S_AOK, !exc, 1'b0};
            act_v = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, cc_en, halted};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL ctrl @%0t: got %b expected %b", $time, act_v, exp_v);
            end
            checks++;
            if ({cyc_cnt, ret_cnt, lu_cnt, mp_cnt} !== {m_cyc, m_ret, m_lu, m_mp}) begin
                errors++;
                $display("FAIL counters @%0t: got cyc=%0d ret=%0d lu=%0d mp=%0d expected cyc=%0d ret=%0d lu=%0d mp=%0d",
                         $time, cyc_cnt, ret_cnt, lu_cnt, mp_cnt, m_cyc, m_ret, m_lu, m_mp);
            end
            checks++;
            if ((D_stall & D_bubble) !== 1'b0) begin
                errors++;
                $display("FAIL stall_bubble_excl @%0t: got D_stall=%b D_bubble=%b expected not both 1",
                         $time, D_stall, D_bubble);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic idle();
        D_icode = I_NOP; E_icode = I_NOP; M_icode = I_NOP; W_icode = I_NOP;
        d_srcA = RNONE;  d_srcB = RNONE;  E_dstM = RNONE;
        e_Cnd = 1'b1;    m_stat = S_AOK;  W_stat = S_AOK;  clr_cnt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        E_icode = I_MRMOVQ; E_dstM = 4'd3; d_srcB = 4'd3;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        // 1: reset, flush, run
        tick(); @(negedge clk);
        lit("rst_D_bubble", 32'(D_bubble), 32'd1);
        lit("rst_F_stall",  32'(F_stall),  32'd1);
        lit("rst_halted",   32'(halted),   32'd0);
        tick(); @(negedge clk);
        tick(); reset = 1'b0; @(negedge clk);
        lit("flush_E_bubble", 32'(E_bubble), 32'd1);
        lit("flush_M_bubble", 32'(M_bubble), 32'd1);
        tick(); @(negedge clk);
        lit("run_D_bubble", 32'(D_bubble), 32'd0);
        lit("run_M_bubble", 32'(M_bubble), 32'd0);
        lit("run_cc_en",    32'(cc_en),    32'd1);
        lit("run_cyc0",     32'(cyc_cnt),  32'd0);
        // 2: load-use
        tick(); set_lu(); @(negedge clk);
        lit("lu_F_stall",  32'(F_stall),  32'd1);
        lit("lu_D_stall",  32'(D_stall),  32'd1);
        lit("lu_E_bubble", 32'(E_bubble), 32'd1);
        lit("lu_D_bubble", 32'(D_bubble), 32'd0);
        lit("lu_cnt_pre",  32'(lu_cnt),   32'd0);
        tick(); idle(); @(negedge clk);
        lit("lu_cnt_post", 32'(lu_cnt), 32'd1);
        // 3: mispredict with ret in D
        tick(); E_icode = I_JXX; e_Cnd = 1'b0; D_icode = I_RET; @(negedge clk);
        lit("mp_D_bubble", 32'(D_bubble), 32'd1);
        lit("mp_E_bubble", 32'(E_bubble), 32'd1);
        lit("mp_F_stall",  32'(F_stall),  32'd1);
        lit("mp_D_stall",  32'(D_stall),  32'd0);
        tick(); idle(); @(negedge clk);
        lit("mp_cnt_post", 32'(mp_cnt), 32'd1);
        // 4: ret walking D -> E -> M
        for (int s = 0; s < 3; s++) begin
            tick(); idle();
            if (s == 0) D_icode = I_RET;
            else if (s == 1) E_icode = I_RET;
            else M_icode = I_RET;
            @(negedge clk);
            lit("ret_F_stall",  32'(F_stall),  32'd1);
            lit("ret_D_bubble", 32'(D_bubble), 32'd1);
        end
        tick(); idle(); @(negedge clk);
        lit("ret_done_F_stall",  32'(F_stall),  32'd0);
        lit("ret_done_D_bubble", 32'(D_bubble), 32'd0);
        // retirement counting
        tick(); W_icode = I_OPQ;
        tick(); W_icode = I_MRMOVQ;
        tick(); idle(); @(negedge clk);
        lit("ret_cnt_2", 32'(ret_cnt), 32'd2);
        // 5: exception then halt
        tick(); m_stat = S_ADR; @(negedge clk);
        lit("exc_M_bubble", 32'(M_bubble), 32'd1);
        lit("exc_cc_en",    32'(cc_en),    32'd0);
        lit("exc_halted",   32'(halted),   32'd0);
        tick(); m_stat = S_AOK; W_stat = S_ADR; W_icode = I_MRMOVQ; @(negedge clk);
        lit("wbad_W_stall", 32'(W_stall), 32'd1);
        lit("wbad_halted",  32'(halted),  32'd0);
        tick(); set_lu(); E_icode = I_POPQ; @(negedge clk);
        lit("halt_halted",   32'(halted),   32'd1);
        lit("halt_D_bubble", 32'(D_bubble), 32'd0);
        lit("halt_lu_cnt",   32'(lu_cnt),   32'd1);
        tick(); W_stat = S_HLT; @(negedge clk);
        lit("halt_lu_frozen",  32'(lu_cnt),  32'd1);
        lit("halt_ret_frozen", 32'(ret_cnt), 32'd2);
        tick(); idle(); reset = 1'b1; @(negedge clk);
        lit("halt_rst_halted",   32'(halted),   32'd1);
        lit("halt_rst_D_bubble", 32'(D_bubble), 32'd1);
        tick(); @(negedge clk);
        lit("after_rst_halted", 32'(halted), 32'd0);
        lit("after_rst_lu",     32'(lu_cnt), 32'd0);
        tick(); reset = 1'b0; @(negedge clk);
        lit("reflush_E_bubble", 32'(E_bubble), 32'd1);
        // 6: saturation and clear priority
        repeat (17) tick();
        @(negedge clk);
        lit("cyc_sat", 32'(cyc_cnt), 32'd15);
        tick(); @(negedge clk);
        lit("cyc_sat_hold", 32'(cyc_cnt), 32'd15);
        tick(); set_lu(); d_srcB = RNONE; d_srcA = 4'd3; W_stat = S_INS; W_stat = S_AOK;
        tick(); set_lu(); clr_cnt = 1'b1; @(negedge clk);
        lit("clr_pre_lu", 32'(lu_cnt), 32'd1);
        tick(); idle(); @(negedge clk);
        lit("clr_lu",  32'(lu_cnt),  32'd0);
        lit("clr_cyc", 32'(cyc_cnt), 32'd0);
        tick(); @(negedge clk);
        lit("cyc_restart", 32'(cyc_cnt), 32'd1);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
